// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Stimulus/readback engine for a 4-input, 1-output combinational circuit.
// Walks the circuit inputs through rows 0..15, waits SETTLE_CYCLES per row,
// takes three synchronized samples of the circuit output, and stores their
// majority in a 16-bit signature (row 0 lands in bit 15). At the end of the
// sweep the signature is compared with EXPECTED.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start, abort     sweep control (abort has priority over start)
//   in1..in4         registered drives to the circuit, in1 is the row MSB
//   dut_out          circuit output, asynchronous to clk
//   busy, done       sweep in progress / one-cycle completion pulse
//   pass             signature == EXPECTED, valid from done onward
//   signature        captured truth table
//   mismatch_mask    signature ^ EXPECTED, valid with pass
module truth_table_sweeper #(
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [15:0] EXPECTED      = 16'h381A,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        in1,
  output logic        in2,
  output logic        in3,
  output logic        in4,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] mismatch_mask
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Majority of three samples rejects a single-cycle glitch.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state_q, state_d;
  logic [3:0]             row_q, row_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [1:0]             smp_cnt_q, smp_cnt_d;
  logic [1:0]             smp_q, smp_d;
  logic [3:0]             in_q, in_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [15:0]            sig_q, sig_d;
  logic [15:0]            mask_q, mask_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   abort_s;
  logic                   maj_s;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  // Abort only matters while a sweep is running; in IDLE it merely blocks start.
  assign abort_s = abort & busy_q;
  assign maj_s   = maj3(smp_q[0], smp_q[1], sync_s);

  // Synchronizer for the asynchronous circuit output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dut_out};
    end
  end

  // Next-state and output computation for the sweep FSM.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    smp_cnt_d = smp_cnt_q;
    smp_d     = smp_q;
    in_d      = in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    sig_d     = sig_q;
    mask_d    = mask_q;

    if (abort_s) begin
      // Partial signature bits are kept; drives return to row 0 with no done.
      state_d = S_IDLE;
      in_d    = 4'd0;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            sig_d   = 16'h0000;
            mask_d  = 16'h0000;
            pass_d  = 1'b0;
            row_d   = 4'd0;
            busy_d  = 1'b1;
            state_d = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DRIVE: begin
          in_d      = row_q;
          cnt_d     = SETTLE_LOAD;
          smp_cnt_d = 2'd0;
          state_d   = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 8'd0) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_SAMPLE: begin
          if (smp_cnt_q == 2'd2) begin
            sig_d[4'd15 - row_q] = maj_s;
            smp_cnt_d            = 2'd0;
            if (row_q == 4'd15) begin
              // Result is registered together with done so pass is valid with it.
              state_d = S_DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (sig_d == EXPECTED);
              mask_d  = sig_d ^ EXPECTED;
            end else begin
              row_d   = row_q + 4'd1;
              state_d = S_DRIVE;
            end
          end else begin
            smp_d[smp_cnt_q[0]] = sync_s;
            smp_cnt_d           = smp_cnt_q + 2'd1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= 4'd0;
      cnt_q     <= 8'd0;
      smp_cnt_q <= 2'd0;
      smp_q     <= 2'd0;
      in_q      <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      sig_q     <= 16'h0000;
      mask_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      smp_cnt_q <= smp_cnt_d;
      smp_q     <= smp_d;
      in_q      <= in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      sig_q     <= sig_d;
      mask_q    <= mask_d;
    end
  end

  assign in1           = in_q[3];
  assign in2           = in_q[2];
  assign in3           = in_q[1];
  assign in4           = in_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = sig_q;
  assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: models the circuit under test as a
// lookup of the golden function 16'h381A with optional per-row faults and
// a one-cycle glitch, then runs table-driven sweeps and corner sequences.
module tb_truth_table_sweeper;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        in1, in2, in3, in4;
  logic        dut_out;
  logic        busy, done, pass;
  logic [15:0] signature, mismatch_mask;

  logic [15:0] golden;
  logic [15:0] fault_mask;
  logic        glitch;
  logic [3:0]  row_s;

  int n_checks;
  int n_errors;

  // Sweep results captured by run_sweep.
  int          r_lat;
  int          r_ndone;
  logic [15:0] r_sig;
  logic        r_pass;
  logic [15:0] r_mask;
  logic        r_busy_done;
  logic [3:0]  r_in_done;
  logic        r_busy1;
  int          row_cnt [16];

  typedef struct {
    logic [15:0] fault;
    logic        glitch_row3;
    logic [15:0] exp_sig;
    logic        exp_pass;
    logic [15:0] exp_mask;
  } vec_t;

  vec_t vecs [5];

  truth_table_sweeper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .in4           (in4),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .signature     (signature),
    .mismatch_mask (mismatch_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign row_s   = {in1, in2, in3, in4};
  assign dut_out = golden[4'd15 - row_s] ^ fault_mask[4'd15 - row_s] ^ glitch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse start, then watch up to 'limit' cycles. Cycle 1 is the one after
  // start acceptance. Extra start pulses at s1/s2, abort pulse at abort_at.
  task run_sweep(input int s1, input int s2, input int abort_at, input int limit);
    logic [3:0] prev;
    logic [3:0] cur;
    r_lat   = -1;
    r_ndone = 0;
    prev    = row_s;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      cur = row_s;
      if (cur != prev) row_cnt[cur]++;
      prev = cur;
      if (c == 1) r_busy1 = busy;
      if (done) begin
        r_ndone++;
        if (r_lat < 0) begin
          r_lat       = c;
          r_sig       = signature;
          r_pass      = pass;
          r_mask      = mismatch_mask;
          r_busy_done = busy;
          r_in_done   = row_s;
        end
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in", {28'd0, row_s}, 32'd0);
      end
      if (abort_at > 0 && c == abort_at) begin
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        abort = 1'b1;
      end
      start = (c == s1 || c == s2) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  // Invert dut_out for exactly one clock so that only the middle sample of
  // row 3 sees the inverted value after the 2-stage synchronizer.
  task glitch_row3();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (row_s == 4'd3) break;
    end
    repeat (7) @(posedge clk);
    @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    golden     = 16'h381A;
    fault_mask = 16'h0000;
    glitch     = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    rst_n      = 1'b0;
    for (int i = 0; i < 16; i++) row_cnt[i] = 0;

    vecs[0] = '{16'h0000, 1'b0, 16'h381A, 1'b1, 16'h0000};
    vecs[1] = '{16'h0400, 1'b0, 16'h3C1A, 1'b0, 16'h0400};
    vecs[2] = '{16'h0000, 1'b1, 16'h381A, 1'b1, 16'h0000};
    vecs[3] = '{16'h8001, 1'b0, 16'hB81B, 1'b0, 16'h8001};
    vecs[4] = '{16'hFFFF, 1'b0, 16'hC7E5, 1'b0, 16'hFFFF};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in", {28'd0, row_s}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_sig", {16'd0, signature}, 32'd0);
    chk("rst_mask", {16'd0, mismatch_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);

    // Table-driven full sweeps
    for (int v = 0; v < 5; v++) begin
      fault_mask = vecs[v].fault;
      if (vecs[v].glitch_row3) begin
        fork
          run_sweep(0, 0, 0, 200);
          glitch_row3();
        join
      end else begin
        run_sweep(0, 0, 0, 200);
      end
      chk($sformatf("v%0d_busy1", v), {31'd0, r_busy1}, 32'd1);
      chk($sformatf("v%0d_lat", v), r_lat, 32'd193);
      chk($sformatf("v%0d_ndone", v), r_ndone, 32'd1);
      chk($sformatf("v%0d_sig", v), {16'd0, r_sig}, {16'd0, vecs[v].exp_sig});
      chk($sformatf("v%0d_pass", v), {31'd0, r_pass}, {31'd0, vecs[v].exp_pass});
      chk($sformatf("v%0d_mask", v), {16'd0, r_mask}, {16'd0, vecs[v].exp_mask});
      chk($sformatf("v%0d_busy_done", v), {31'd0, r_busy_done}, 32'd0);
      chk($sformatf("v%0d_in_done", v), {28'd0, r_in_done}, 32'd15);
      chk($sformatf("v%0d_in_hold", v), {28'd0, row_s}, 32'd15);
    end
    fault_mask = 16'h0000;

    // Extra start pulses while busy; inputs start at row 15 so every row shows as a change
    for (int i = 0; i < 16; i++) row_cnt[i] = 0;
    run_sweep(10, 100, 0, 260);
    chk("dbl_lat", r_lat, 32'd193);
    chk("dbl_ndone", r_ndone, 32'd1);
    chk("dbl_pass", {31'd0, r_pass}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("dbl_row%0d", i), row_cnt[i], 32'd1);
    end

    // Abort at cycle 60, no done pulse, then a fresh sweep passes
    run_sweep(0, 0, 60, 250);
    chk("abort_ndone", r_ndone, 32'd0);
    chk("abort_pass", {31'd0, pass}, 32'd0);
    run_sweep(0, 0, 0, 200);
    chk("post_abort_lat", r_lat, 32'd193);
    chk("post_abort_pass", {31'd0, r_pass}, 32'd1);

    // Reset asserted mid-SETTLE of row 7
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (row_s == 4'd7) break;
      @(posedge clk);
      #1;
    end
    chk("mid_row7_reached", {28'd0, row_s}, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in", {28'd0, row_s}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_pass", {31'd0, pass}, 32'd0);
    chk("arst_sig", {16'd0, signature}, 32'd0);
    chk("arst_mask", {16'd0, mismatch_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_sweep(0, 0, 0, 200);
    chk("post_rst_lat", r_lat, 32'd193);
    chk("post_rst_sig", {16'd0, r_sig}, 32'h381A);
    chk("post_rst_pass", {31'd0, r_pass}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
